// File: rtl/mbist_march.sv
// mbist_march: March-algorithm SRAM BIST engine (MATS+, March C-, March X), one op per cycle.
// Define MBIST_ERR_LOG_EN to keep the saturating error counter and first-failure capture.
module mbist_march #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one memory op per cycle
    // FLUSH | compare of the final read
    // DONE  | one-cycle completion pulse, pass updated
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [1:0] ALG_MATS   = 2'd0;
    localparam logic [1:0] ALG_MARCHC = 2'd1;
    localparam logic [1:0] ALG_MARCHX = 2'd2;

    function automatic logic [2:0] last_elem(input logic [1:0] alg);
        case (alg)
            ALG_MATS:   return 3'd2;
            ALG_MARCHX: return 3'd3;
            default:    return 3'd5;
        endcase
    endfunction

    function automatic logic elem_desc(input logic [1:0] alg, input logic [2:0] elem);
        case (alg)
            ALG_MATS, ALG_MARCHX: return elem == 3'd2;
            default:              return (elem == 3'd3) || (elem == 3'd4);
        endcase
    endfunction

    // Element 0 is w0; a final single-op element (March C-/X) is r0; the rest are (r~e0, we0).
    function automatic logic elem_two_op(input logic [1:0] alg, input logic [2:0] elem);
        return (elem != 3'd0) && !((alg != ALG_MATS) && (elem == last_elem(alg)));
    endfunction

    state_t            state_q;
    logic [1:0]        alg_q;
    logic [2:0]        elem_q;
    logic              op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              pass_q;
    logic              fail_q;
    logic              cmp_valid_q;
    logic [DATA_W-1:0] cmp_exp_q;

    logic cur_two, cur_read, cur_val, cur_desc, addr_end, last_op, in_run;
    logic miscompare, start_run;

    always_comb begin
        cur_two  = elem_two_op(alg_q, elem_q);
        cur_read = cur_two ? !op_q : (elem_q != 3'd0);
        cur_val  = cur_two && (op_q ? elem_q[0] : !elem_q[0]);
        cur_desc = elem_desc(alg_q, elem_q);
        addr_end = cur_desc ? (addr_q == '0) : (addr_q == '1);
        last_op  = !cur_two || op_q;
        in_run   = (state_q == RUN);
    end

    assign miscompare = cmp_valid_q && (mem_rdata != cmp_exp_q);
    assign start_run  = (state_q == IDLE) && start && !abort;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign mem_we    = in_run && !cur_read;
    assign mem_re    = in_run && cur_read;
    assign mem_addr  = in_run ? addr_q : '0;
    assign mem_wdata = mem_we ? {DATA_W{cur_val}} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alg_q       <= ALG_MATS;
            elem_q      <= 3'd0;
            op_q        <= 1'b0;
            addr_q      <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_exp_q   <= '0;
        end else begin
            cmp_valid_q <= 1'b0;
            if (miscompare)
                fail_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start_run) begin
                        state_q <= RUN;
                        alg_q   <= (mode == 2'd3) ? ALG_MARCHC : mode;
                        elem_q  <= 3'd0;
                        op_q    <= 1'b0;
                        addr_q  <= '0;
                        pass_q  <= 1'b0;
                        fail_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        pass_q  <= 1'b0;
                    end else begin
                        if (cur_read) begin
                            cmp_valid_q <= 1'b1;
                            cmp_exp_q   <= {DATA_W{cur_val}};
                        end
                        if (!last_op) begin
                            op_q <= 1'b1;
                        end else begin
                            op_q <= 1'b0;
                            if (addr_end) begin
                                if (elem_q == last_elem(alg_q)) begin
                                    state_q <= FLUSH;
                                end else begin
                                    elem_q <= elem_q + 3'd1;
                                    addr_q <= elem_desc(alg_q, elem_q + 3'd1) ? '1 : '0;
                                end
                            end else begin
                                addr_q <= cur_desc ? addr_q - 1'b1 : addr_q + 1'b1;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (abort) begin
                        state_q <= IDLE;
                        pass_q  <= 1'b0;
                    end else begin
                        state_q <= DONE;
                        pass_q  <= !(fail_q || miscompare);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    if (abort)
                        pass_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef MBIST_ERR_LOG_EN
    logic [ADDR_W-1:0] cmp_addr_q;
    logic [ERR_W-1:0]  err_q;
    logic [ADDR_W-1:0] ferr_addr_q;
    logic [DATA_W-1:0] ferr_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_addr_q  <= '0;
            err_q       <= '0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
        end else begin
            if (in_run && !abort && cur_read)
                cmp_addr_q <= addr_q;
            if (start_run) begin
                err_q       <= '0;
                ferr_addr_q <= '0;
                ferr_data_q <= '0;
            end else if (miscompare) begin
                if (err_q != '1)
                    err_q <= err_q + 1'b1;
                // The counter never returns to zero within a run, so zero marks the first miscompare.
                if (err_q == '0) begin
                    ferr_addr_q <= cmp_addr_q;
                    ferr_data_q <= mem_rdata;
                end
            end
        end
    end

    assign err_count      = err_q;
    assign first_err_addr = ferr_addr_q;
    assign first_err_data = ferr_data_q;
`else
    assign err_count      = '0;
    assign first_err_addr = '0;
    assign first_err_data = '0;
`endif

endmodule

// File: doc/mbist_march.md
# mbist_march

Parametrised March-algorithm memory BIST engine for on-chip SRAMs, selectable per run among MATS+, March C- and March X. It is the successor to the fixed-depth RUNBIST engine, generalising it in data width, depth and algorithm. It sits behind the JTAG TAP: the RUNBIST instruction drives `start`/`mode`, and GETTEST/DR scans read `pass`, `err_count` and the captured first-failure information. Memory access is single-port, one operation per cycle, with a one-cycle read latency.

## Interface
- `DATA_W`, 8: memory word width.
- `ADDR_W`, 8: address width; DEPTH = 2^ADDR_W words.
- `ERR_W`, 8: width of the saturating error counter.
- `clk`  in  1  BIST clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled; starts a run when idle.
- `mode`  in  2  algorithm, sampled with `start`: 0 = MATS+, 1 = March C-, 2 = March X, 3 = reserved (treated as March C-).
- `abort`  in  1  ends a run immediately.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle completion pulse; not raised on abort.
- `pass`  out  1  result of the last completed run.
- `err_count`  out  ERR_W  number of miscompares, saturating.
- `first_err_addr`  out  ADDR_W  address of the first miscompare.
- `first_err_data`  out  DATA_W  read data of the first miscompare.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_we`  out  1  write strobe.
- `mem_re`  out  1  read strobe.
- `mem_wdata`  out  DATA_W  write data: all-0 or all-1.
- `mem_rdata`  in  DATA_W  read data, valid the cycle after `mem_re`.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - `start`=1 latches `mode`, clears `err_count`, `first_err_*` and `pass`.
  - Goes to RUN with element 0, op 0, address at the element's start.
- Algorithms (u = ascending, d = descending, x = ascending):
  - MATS+: x(w0); u(r0,w1); d(r1,w0). 5 ops per word.
  - March C-: x(w0); u(r0,w1); u(r1,w0); d(r0,w1); d(r1,w0); x(r0). 10 ops per word.
  - March X: x(w0); u(r0,w1); d(r1,w0); x(r0). 6 ops per word.
- RUN:
  - Issues exactly one op per cycle through combinational outputs from the element/op/address registers.
  - Ops in an element run in order at one address, then the address steps (+1 or -1).
  - At the end of the element's address range, the next element starts with no idle cycle.
  - Wrap-around: ascending range 0 to DEPTH-1; descending DEPTH-1 to 0. The address counter must not wrap mid-element.
- Compare pipeline:
  - A read issued in cycle t registers its expected value and address.
  - `mem_rdata` is compared in cycle t+1.
  - On a miscompare, `err_count` increments and saturates at 2^ERR_W-1.
  - The first miscompare of a run loads `first_err_addr`/`first_err_data`.
- FLUSH: one cycle after the last op so the final read can be compared.
- DONE: one cycle; `done`=1; `pass` = (`err_count`==0); then back to IDLE.
- `start` is ignored while `busy`.
- `abort` in any non-IDLE state goes to IDLE next edge: no `done`, `pass`=0, error registers kept.
- If `abort` and `start` are both high in IDLE, abort wins and no run starts.

## Timing
- Reset values: `busy`, `done`, `pass`, `mem_we`, `mem_re` = 0; `err_count`, `first_err_*`, `mem_addr`, `mem_wdata` = 0.
- Let K = ops_per_word × DEPTH.
  - `busy` rises on the edge that samples `start`.
  - Ops occupy the next K cycles, then FLUSH.
  - `done` is high for 1 cycle, K+1 cycles after `busy` rises.
  - `busy` falls with `done`.
- `mem_we` and `mem_re` are never both high; both are low outside RUN.
- `rst_n` low mid-run returns all outputs to reset values asynchronously; the run is not resumed.

## Configuration
- `MBIST_ERR_LOG_EN` defined:
  - `err_count`, `first_err_addr` and `first_err_data` are implemented as above.
- Undefined:
  - Those three outputs are tied to 0.
  - Only a 1-bit sticky fail flag is kept; `pass` is its inverse at DONE.
  - Pass/fail behaviour and timing are identical.

## Test plan
- ADDR_W=2, DATA_W=8, mode=0, fault-free model: `done` 21 cycles after `busy` rises; `pass`=1; `err_count`=0; 20 ops in order w0×4, (r0,w1)×4 ascending, (r1,w0)×4 descending.
- mode=1, ADDR_W=4: `done` 161 cycles after `busy` rises; `pass`=1; last op is r0 @0xF; the FLUSH-cycle compare is exercised.
- Stuck-at-1 on bit 3 of address 5, mode=1 (defines an `err_count` of 3 for this fault), macro on: `pass`=0, `err_count`=3, `first_err_addr`=5, `first_err_data`=0x08.
  - Same fault, macro off: `pass`=0; `err_count` and `first_err_*` read 0.
- Every word faulty, ERR_W=2, mode=1: `err_count` saturates at 3; `pass`=0.
- `abort` at op 7 of MATS+: `busy` drops next edge, no `done`, `pass`=0.
  - A following `start` runs a clean MATS+ to `pass`=1.
- `rst_n` pulsed low mid-run: all outputs at reset values while low.
  - `start` held high through the `rst_n` release begins a fresh run on the first edge after release.
